// File: rtl/ifm_pkg.sv
// ifm_pkg: shared definitions for the S2MM-side RX drain FSM (ifm_out_fsm).
//   - FSM state encoding (also exported on the debug port)
//   - Bit offsets of the FWFT ctrl (status) and data FIFO entries
//   - Status packet geometry and word index constants
package ifm_pkg;

    // Encoding is visible on ifm_out_fsm_dbg, so values are pinned explicitly.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StDrop = 2'd2,
        StSts  = 2'd3
    } ifm_state_e;

    // Ctrl FIFO entry: [15:0] frame bytes, [16] good, [63:17] reserved
    localparam int unsigned CTRL_W   = 64;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_MSB  = 15;
    localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned GOOD_BIT = 16;

    // Data FIFO entry: [63:0] data, [71:64] keep, [72] last
    localparam int unsigned DATA_FIFO_W = 73;
    localparam int unsigned DATA_LSB    = 0;
    localparam int unsigned DATA_MSB    = 63;
    localparam int unsigned KEEP_LSB    = 64;
    localparam int unsigned KEEP_MSB    = 71;
    localparam int unsigned LAST_BIT    = 72;

    // Status packet: six 32-bit words, tag in word 0, frame length in word 5
    localparam int unsigned STS_WORDS = 6;
    localparam int unsigned STS_IDX_W = 3;

    localparam logic [STS_IDX_W-1:0] STS_IDX_TAG  = 3'd0;
    localparam logic [STS_IDX_W-1:0] STS_IDX_LEN  = 3'd5;
    localparam logic [STS_IDX_W-1:0] STS_IDX_LAST = 3'(STS_WORDS - 1);

endpackage

// File: rtl/ifm_out_fsm.sv
// ifm_out_fsm: receive-path S2MM drain FSM.
// Pops a completed (store-and-forward) frame from the RX data FIFO and forwards it on the rxd
// AXI-Stream, then emits a 6-word status packet on rxs. Frames marked bad in the ctrl entry are
// drained without being forwarded and counted in a saturating drop counter.
//
// Ports
//   s2mm_clk, s2mm_resetn         clock, asynchronous active-low reset
//   ctrl_fifo_rdata/empty/rden    FWFT status FIFO: {.., good, len[15:0]}; rden pops one entry
//   data_fifo_rdata/empty/rden    FWFT data FIFO: {last, keep[7:0], data[63:0]}
//   rxd_t*                        frame data AXI-Stream master (64-bit)
//   rxs_t*                        status AXI-Stream master (32-bit)
//   drop_cnt                      number of discarded frames, saturating
//   ifm_out_fsm_dbg               {2'b0, state}
module ifm_out_fsm
    import ifm_pkg::*;
#(
    parameter logic [3:0]  C_STS_TAG        = 4'h5,
    parameter int unsigned C_DROP_CNT_WIDTH = 16
) (
    input  logic                        s2mm_clk,
    input  logic                        s2mm_resetn,

    input  logic [CTRL_W-1:0]           ctrl_fifo_rdata,
    input  logic                        ctrl_fifo_empty,
    output logic                        ctrl_fifo_rden,

    input  logic [DATA_FIFO_W-1:0]      data_fifo_rdata,
    input  logic                        data_fifo_empty,
    output logic                        data_fifo_rden,

    output logic [63:0]                 rxd_tdata,
    output logic [7:0]                  rxd_tkeep,
    output logic                        rxd_tvalid,
    output logic                        rxd_tlast,
    input  logic                        rxd_tready,

    output logic [31:0]                 rxs_tdata,
    output logic [3:0]                  rxs_tkeep,
    output logic                        rxs_tvalid,
    output logic                        rxs_tlast,
    input  logic                        rxs_tready,

    output logic [C_DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic [3:0]                  ifm_out_fsm_dbg
);

    ifm_state_e                  state_q, state_d;
    logic [STS_IDX_W-1:0]        sts_idx_q, sts_idx_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [C_DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic data_last;
    logic sts_last;

    assign data_last = data_fifo_rdata[LAST_BIT];
    assign sts_last  = (sts_idx_q == STS_IDX_LAST);

    // Reserved ctrl bits are carried by the FIFO but have no meaning here.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl_fifo_rdata[CTRL_W-1:GOOD_BIT+1];

    // State register
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            state_q    <= StIdle;
            sts_idx_q  <= '0;
            len_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sts_idx_q  <= sts_idx_d;
            len_q      <= len_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        sts_idx_d  = sts_idx_q;
        len_d      = len_q;
        drop_cnt_d = drop_cnt_q;

        unique case (state_q)
            StIdle: begin
                // Ctrl entry is only peeked here; it is popped once the frame is fully retired.
                if (!ctrl_fifo_empty) begin
                    len_d   = ctrl_fifo_rdata[LEN_MSB:LEN_LSB];
                    state_d = ctrl_fifo_rdata[GOOD_BIT] ? StData : StDrop;
                end
            end
            StData: begin
                if (!data_fifo_empty && rxd_tready && data_last) begin
                    state_d = StSts;
                end
            end
            StDrop: begin
                if (!data_fifo_empty && data_last) begin
                    state_d = StIdle;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            StSts: begin
                if (rxs_tready) begin
                    if (sts_last) begin
                        sts_idx_d = '0;
                        state_d   = StIdle;
                    end else begin
                        sts_idx_d = sts_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: only the FIFO pops look at tready, so payload/valid stay stable under backpressure.
    always_comb begin
        ctrl_fifo_rden = 1'b0;
        data_fifo_rden = 1'b0;
        rxd_tdata      = '0;
        rxd_tkeep      = '0;
        rxd_tvalid     = 1'b0;
        rxd_tlast      = 1'b0;
        rxs_tdata      = '0;
        rxs_tkeep      = '0;
        rxs_tvalid     = 1'b0;
        rxs_tlast      = 1'b0;

        unique case (state_q)
            StIdle: ;
            StData: begin
                // Zero-latency pass-through of the FWFT head.
                rxd_tvalid     = !data_fifo_empty;
                rxd_tdata      = data_fifo_rdata[DATA_MSB:DATA_LSB];
                rxd_tkeep      = data_fifo_rdata[KEEP_MSB:KEEP_LSB];
                rxd_tlast      = data_last;
                data_fifo_rden = !data_fifo_empty && rxd_tready;
            end
            StDrop: begin
                data_fifo_rden = !data_fifo_empty;
                ctrl_fifo_rden = !data_fifo_empty && data_last;
            end
            StSts: begin
                rxs_tvalid = 1'b1;
                rxs_tkeep  = 4'hF;
                rxs_tlast  = sts_last;
                case (sts_idx_q)
                    STS_IDX_TAG: rxs_tdata = {C_STS_TAG, 28'h0};
                    STS_IDX_LEN: rxs_tdata = {16'h0, len_q};
                    default:     rxs_tdata = 32'h0;
                endcase
                ctrl_fifo_rden = rxs_tready && sts_last;
            end
            default: ;
        endcase
    end

    assign drop_cnt        = drop_cnt_q;
    assign ifm_out_fsm_dbg = {2'b00, state_q};

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Testbench for ifm_out_fsm. Behavioural FIFOs feed the DUT; each submitted frame appends the
// beats and status words it must produce to expectation queues, which are checked on every
// handshake together with AXI-Stream stability and exclusivity rules.
module tb_ifm_out_fsm;

    logic        clk = 1'b0;
    logic        s2mm_resetn;
    logic [63:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty;
    logic        ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty;
    logic        data_fifo_rden;
    logic [63:0] rxd_tdata;
    logic [7:0]  rxd_tkeep;
    logic        rxd_tvalid;
    logic        rxd_tlast;
    logic        rxd_tready;
    logic [31:0] rxs_tdata;
    logic [3:0]  rxs_tkeep;
    logic        rxs_tvalid;
    logic        rxs_tlast;
    logic        rxs_tready;
    logic [15:0] drop_cnt;
    logic [3:0]  dbg;

    always #5 clk = ~clk;

    ifm_out_fsm #(
        .C_STS_TAG        (4'h5),
        .C_DROP_CNT_WIDTH (16)
    ) dut (
        .s2mm_clk        (clk),
        .s2mm_resetn     (s2mm_resetn),
        .ctrl_fifo_rdata (ctrl_fifo_rdata),
        .ctrl_fifo_empty (ctrl_fifo_empty),
        .ctrl_fifo_rden  (ctrl_fifo_rden),
        .data_fifo_rdata (data_fifo_rdata),
        .data_fifo_empty (data_fifo_empty),
        .data_fifo_rden  (data_fifo_rden),
        .rxd_tdata       (rxd_tdata),
        .rxd_tkeep       (rxd_tkeep),
        .rxd_tvalid      (rxd_tvalid),
        .rxd_tlast       (rxd_tlast),
        .rxd_tready      (rxd_tready),
        .rxs_tdata       (rxs_tdata),
        .rxs_tkeep       (rxs_tkeep),
        .rxs_tvalid      (rxs_tvalid),
        .rxs_tlast       (rxs_tlast),
        .rxs_tready      (rxs_tready),
        .drop_cnt        (drop_cnt),
        .ifm_out_fsm_dbg (dbg)
    );

    // FIFO contents and expectations
    logic [72:0] data_q[$];
    logic [63:0] ctrl_q[$];
    logic [72:0] exp_rxd[$];
    logic [32:0] exp_rxs[$];
    logic [63:0] rxd_log[$];
    logic [31:0] rxs_log[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          data_pops, ctrl_pops, exp_data_pops, exp_ctrl_pops;
    logic [15:0] exp_drops;
    bit          data_block;
    bit          rxd_toggle;
    bit          rxd_hold, rxs_hold;
    logic [72:0] rxd_prev;
    logic [36:0] rxs_prev;
    logic [72:0] junk73;
    logic [63:0] junk64;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void refresh();
        data_fifo_empty = (data_q.size() == 0) || data_block;
        data_fifo_rdata = (data_q.size() != 0) ? data_q[0] : '0;
        ctrl_fifo_empty = (ctrl_q.size() == 0);
        ctrl_fifo_rdata = (ctrl_q.size() != 0) ? ctrl_q[0] : '0;
    endfunction

    // Queue a frame in the FIFOs and record what the DUT must do with it.
    function automatic void send_frame(input int nbeats, input bit good, input logic [15:0] len,
                                       input logic [7:0] last_keep, input logic [7:0] fid);
        logic [72:0] beat;
        for (int i = 0; i < nbeats; i++) begin
            beat = {(i == nbeats - 1), (i == nbeats - 1) ? last_keep : 8'hFF,
                    fid, 8'(i), 16'h5A5A, 32'(i * 3 + 1)};
            data_q.push_back(beat);
            if (good) exp_rxd.push_back(beat);
        end
        // Reserved bits set to prove they are ignored.
        ctrl_q.push_back({47'h1234, good, len});
        if (good) begin
            exp_rxs.push_back({1'b0, 4'h5, 28'h0});
            for (int i = 0; i < 4; i++) exp_rxs.push_back(33'h0);
            exp_rxs.push_back({1'b1, 16'h0, len});
        end else if (exp_drops != 16'hFFFF) begin
            exp_drops++;
        end
        exp_data_pops += nbeats;
        exp_ctrl_pops += 1;
        refresh();
    endfunction

    // One clock: check at the falling edge, apply FIFO pops just after the rising edge.
    task automatic tick();
        bit pd, pc;
        pd = 1'b0;
        pc = 1'b0;
        @(negedge clk);
        if (s2mm_resetn) begin
            chk("valid_exclusive", rxd_tvalid & rxs_tvalid, 1'b0);
            if (rxd_hold) chk("rxd_stable", {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
                              {1'b1, rxd_prev});
            if (rxs_hold) chk("rxs_stable", {rxs_tvalid, rxs_tlast, rxs_tkeep, rxs_tdata},
                              {1'b1, rxs_prev});
            if (rxd_tvalid && rxd_tready) begin
                if (exp_rxd.size() == 0) chk("rxd_unexpected", rxd_tvalid, 1'b0);
                else chk("rxd_beat", {rxd_tlast, rxd_tkeep, rxd_tdata}, exp_rxd.pop_front());
                rxd_log.push_back(rxd_tdata);
            end
            if (rxs_tvalid) chk("rxs_tkeep", rxs_tkeep, 4'hF);
            if (rxs_tvalid && rxs_tready) begin
                if (exp_rxs.size() == 0) chk("rxs_unexpected", rxs_tvalid, 1'b0);
                else chk("rxs_word", {rxs_tlast, rxs_tdata}, exp_rxs.pop_front());
                rxs_log.push_back(rxs_tdata);
            end
            if (data_fifo_rden) begin
                chk("data_pop_nonempty", data_fifo_empty, 1'b0);
                pd = 1'b1;
            end
            if (ctrl_fifo_rden) begin
                chk("ctrl_pop_nonempty", ctrl_fifo_empty, 1'b0);
                pc = 1'b1;
            end
            rxd_hold = rxd_tvalid && !rxd_tready;
            rxs_hold = rxs_tvalid && !rxs_tready;
            rxd_prev = {rxd_tlast, rxd_tkeep, rxd_tdata};
            rxs_prev = {rxs_tlast, rxs_tkeep, rxs_tdata};
        end else begin
            rxd_hold = 1'b0;
            rxs_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pd && data_q.size() != 0) begin
            junk73 = data_q.pop_front();
            data_pops++;
        end
        if (pc && ctrl_q.size() != 0) begin
            junk64 = ctrl_q.pop_front();
            ctrl_pops++;
        end
        if (rxd_toggle) rxd_tready = !rxd_tready;
        refresh();
    endtask

    // Run until the frame is fully retired, then check pop and drop bookkeeping.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(exp_rxd.size() == 0 && exp_rxs.size() == 0 && data_q.size() == 0 &&
                 ctrl_q.size() == 0 && dbg == 4'd0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: frame not retired within 300 cycles", name);
        end
        tick();
        chk({name, "_data_pops"}, data_pops, exp_data_pops);
        chk({name, "_ctrl_pops"}, ctrl_pops, exp_ctrl_pops);
        chk({name, "_drop_cnt"}, drop_cnt, exp_drops);
    endtask

    task automatic wait_until_rxs_left(input int left);
        int n;
        n = 0;
        while (exp_rxs.size() != left && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL rxs_progress_timeout: %0d words left, waiting for %0d",
                     exp_rxs.size(), left);
        end
    endtask

    initial begin
        int n;
        int c0;
        s2mm_resetn   = 1'b0;
        rxd_tready    = 1'b1;
        rxs_tready    = 1'b1;
        data_block    = 1'b0;
        rxd_toggle    = 1'b0;
        rxd_hold      = 1'b0;
        rxs_hold      = 1'b0;
        data_pops     = 0;
        ctrl_pops     = 0;
        exp_data_pops = 0;
        exp_ctrl_pops = 0;
        exp_drops     = '0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dbg", dbg, 4'd0);
        chk("reset_drop_cnt", drop_cnt, 16'd0);
        chk("reset_valids", {rxd_tvalid, rxs_tvalid, rxd_tlast, rxs_tlast}, 4'b0);
        chk("reset_rden", {data_fifo_rden, ctrl_fifo_rden}, 2'b0);
        chk("reset_payload", {rxd_tdata, rxd_tkeep, rxs_tdata, rxs_tkeep}, '0);
        s2mm_resetn = 1'b1;
        tick();

        // 1-beat good frame
        rxd_log.delete();
        rxs_log.delete();
        send_frame(1, 1'b1, 16'd4, 8'h0F, 8'hA1);
        wait_done("t1");
        chk("t1_rxd_beats", rxd_log.size(), 1);
        chk("t1_rxs_words", rxs_log.size(), 6);
        if (rxs_log.size() == 6) begin
            chk("t1_rxs_w0", rxs_log[0], 32'h5000_0000);
            chk("t1_rxs_w5", rxs_log[5], 32'h0000_0004);
        end

        // 3-beat frame with rxd_tready toggling
        rxd_log.delete();
        rxs_log.delete();
        rxd_toggle = 1'b1;
        send_frame(3, 1'b1, 16'd20, 8'h0F, 8'hB2);
        wait_done("t2");
        rxd_toggle = 1'b0;
        rxd_tready = 1'b1;
        chk("t2_rxd_beats", rxd_log.size(), 3);
        if (rxs_log.size() == 6) chk("t2_rxs_w5", rxs_log[5], 32'h0000_0014);

        // Bad frame drained silently
        rxd_log.delete();
        rxs_log.delete();
        c0 = data_pops;
        send_frame(4, 1'b0, 16'd32, 8'hFF, 8'hC3);
        wait_done("t3");
        chk("t3_drop_cnt_lit", drop_cnt, 16'd1);
        chk("t3_data_pops_lit", data_pops - c0, 4);
        chk("t3_no_rxd", rxd_log.size(), 0);
        chk("t3_no_rxs", rxs_log.size(), 0);

        // rxs backpressure at status word 2
        rxs_log.delete();
        send_frame(2, 1'b1, 16'd16, 8'hFF, 8'hD4);
        wait_until_rxs_left(4);
        rxs_tready = 1'b0;
        c0 = ctrl_pops;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_rxs_valid_held", rxs_tvalid, 1'b1);
            chk("t4_rxs_word2", rxs_tdata, 32'h0);
        end
        chk("t4_no_ctrl_pop", ctrl_pops, c0);
        chk("t4_dbg_sts", dbg, 4'd3);
        rxs_tready = 1'b1;
        wait_done("t4");
        if (rxs_log.size() == 6) chk("t4_rxs_w5", rxs_log[5], 32'h0000_0010);

        // Data FIFO runs dry mid-frame
        rxd_log.delete();
        send_frame(4, 1'b1, 16'd30, 8'h3F, 8'hE5);
        n = 0;
        while (exp_rxd.size() != 3 && n < 50) begin
            tick();
            n++;
        end
        data_block = 1'b1;
        refresh();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_rxd_idle", rxd_tvalid, 1'b0);
            chk("t5_dbg_data", dbg, 4'd1);
        end
        data_block = 1'b0;
        refresh();
        wait_done("t5");
        chk("t5_rxd_beats", rxd_log.size(), 4);

        // Reset asserted during status word 3
        send_frame(1, 1'b1, 16'd8, 8'hFF, 8'hF6);
        wait_until_rxs_left(3);
        chk("t6_dbg_sts", dbg, 4'd3);
        s2mm_resetn = 1'b0;
        #1;
        chk("t6_valids_cleared", {rxd_tvalid, rxs_tvalid, rxs_tlast}, 3'b0);
        chk("t6_rden_cleared", {data_fifo_rden, ctrl_fifo_rden}, 2'b0);
        chk("t6_dbg_idle", dbg, 4'd0);
        chk("t6_drop_cnt_cleared", drop_cnt, 16'd0);
        // FIFOs share the reset, so everything in flight is gone.
        data_q.delete();
        ctrl_q.delete();
        exp_rxd.delete();
        exp_rxs.delete();
        data_pops     = 0;
        ctrl_pops     = 0;
        exp_data_pops = 0;
        exp_ctrl_pops = 0;
        exp_drops     = '0;
        refresh();
        tick();
        tick();
        s2mm_resetn = 1'b1;
        tick();
        rxd_log.delete();
        rxs_log.delete();
        send_frame(2, 1'b1, 16'd12, 8'h0F, 8'h17);
        wait_done("t6");
        chk("t6_rxd_beats", rxd_log.size(), 2);
        if (rxs_log.size() == 6) begin
            chk("t6_rxs_w0", rxs_log[0], 32'h5000_0000);
            chk("t6_rxs_w5", rxs_log[5], 32'h0000_000C);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
